// File: rtl/pc_ctrl_if.sv
// Fetch-stage program-counter bus: redirect/halt controls into pc_ctrl, PC and status out.
// master = hazard/decode side, slave = pc_ctrl.
interface pc_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int FCNT_W = 16
);
    logic              en;
    logic              branchmux;
    logic [PC_W-1:0]   immext;
    logic              jumpmux;
    logic [25:0]       imm26;
    logic              jrmux;
    logic [PC_W-1:0]   jr_target;
    logic              call_push;
    logic              ret_pop;
    logic              halt;
    logic [PC_W-1:0]   imemaddr;
    logic [PC_W-1:0]   pc_plus4;
    logic              pend_valid;
    logic              halted;
    logic [FCNT_W-1:0] fetch_count;
    logic [PC_W-1:0]   ras_top;

    modport master (
        output en, branchmux, immext, jumpmux, imm26, jrmux, jr_target,
               call_push, ret_pop, halt,
        input  imemaddr, pc_plus4, pend_valid, halted, fetch_count, ras_top
    );

    modport slave (
        input  en, branchmux, immext, jumpmux, imm26, jrmux, jr_target,
               call_push, ret_pop, halt,
        output imemaddr, pc_plus4, pend_valid, halted, fetch_count, ras_top
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: prioritised redirects, stall-pending redirect, halt, fetch counter.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_ctrl #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              FCNT_W    = 16,
    parameter int              RAS_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    pc_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_HALT} state_t;

    // Low 28 bits come from the jump immediate; the rest from pc_plus4.
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'({28{1'b1}});

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_q, pend_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   jump_target;
    logic [PC_W-1:0]   jr_eff_target;
    logic [PC_W-1:0]   redirect_target;
    logic [PC_W-1:0]   ras_top;
    logic              redirect_req;
    logic              advance;

    assign pc_plus4     = pc_q + PC_W'(4);
    assign jump_target  = (pc_plus4 & ~LOW_MASK) | PC_W'({bus.imm26, 2'b00});
    assign redirect_req = bus.jrmux | bus.jumpmux | bus.branchmux;
    assign advance      = bus.en && (state_q != ST_HALT);

    always_comb begin
        if (bus.jrmux)        redirect_target = jr_eff_target;
        else if (bus.jumpmux) redirect_target = jump_target;
        else                  redirect_target = bus.immext;
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_occ;
    logic             ras_pop_hit;
    logic             do_push;
    logic             do_pop;

    assign ras_pop_hit = bus.jrmux & bus.ret_pop & (ras_occ != '0);
    assign do_pop      = advance & ras_pop_hit;
    assign do_push     = advance & bus.call_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_occ <= '0;
        end else if (do_push && !do_pop) begin
            // Overflow wraps the pointer onto the oldest entry.
            ras_ptr <= PTR_W'(ras_ptr + 1'b1);
            if (ras_occ != (PTR_W+1)'(RAS_DEPTH)) ras_occ <= ras_occ + 1'b1;
        end else if (do_pop && !do_push) begin
            ras_ptr <= PTR_W'(ras_ptr - 1'b1);
            ras_occ <= ras_occ - 1'b1;
        end
    end

    // NOTE: stack storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) ras_mem[do_pop ? ras_ptr : PTR_W'(ras_ptr + 1'b1)] <= pc_plus4;
    end

    assign ras_top       = (ras_occ != '0) ? ras_mem[ras_ptr] : '0;
    assign jr_eff_target = ras_pop_hit ? ras_top : bus.jr_target;
`else
    logic unused_ras;
    assign unused_ras    = bus.call_push ^ bus.ret_pop;
    assign ras_top       = '0;
    assign jr_eff_target = bus.jr_target;
`endif

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        if (advance) begin
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
            if (bus.halt) begin
                // Halt freezes on its own PC and discards any redirect.
                state_d = ST_HALT;
            end else if (redirect_req) begin
                pc_d    = redirect_target;
                state_d = ST_RUN;
            end else if (state_q == ST_PEND) begin
                pc_d    = pend_q;
                state_d = ST_RUN;
            end else begin
                pc_d    = pc_plus4;
            end
        end else if (state_q != ST_HALT && redirect_req) begin
            pend_d  = redirect_target;
            state_d = ST_PEND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.imemaddr    = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.pend_valid  = (state_q == ST_PEND);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fetch_count = fcnt_q;
    assign bus.ras_top     = ras_top;
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: reset, redirect priority, stall pending, halt, wrap, saturation, RAS.
module tb_pc_ctrl;
    localparam int PC_W   = 32;
    localparam int FCNT_W = 4;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pc_ctrl_if #(.PC_W(PC_W), .FCNT_W(FCNT_W)) bus ();

    pc_ctrl #(
        .PC_W      (PC_W),
        .RESET_PC  (32'h0000_0000),
        .FCNT_W    (FCNT_W),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.en        = 1'b0;
        bus.branchmux = 1'b0;
        bus.immext    = '0;
        bus.jumpmux   = 1'b0;
        bus.imm26     = '0;
        bus.jrmux     = 1'b0;
        bus.jr_target = '0;
        bus.call_push = 1'b0;
        bus.ret_pop   = 1'b0;
        bus.halt      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        check("rst_pc",      64'(bus.imemaddr),    64'h0);
        check("rst_pend",    64'(bus.pend_valid),  64'h0);
        check("rst_halted",  64'(bus.halted),      64'h0);
        check("rst_fcnt",    64'(bus.fetch_count), 64'h0);
        check("rst_rastop",  64'(bus.ras_top),     64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch
        bus.en = 1'b1;
        check("seq_pc0", 64'(bus.imemaddr), 64'h0);
        tick(); check("seq_pc1",   64'(bus.imemaddr), 64'h4);
        check("plus4", 64'(bus.pc_plus4), 64'h8);
        tick(); check("seq_pc2",   64'(bus.imemaddr), 64'h8);
        tick(); check("seq_pc3",   64'(bus.imemaddr), 64'hC);
        tick(); check("seq_fcnt4", 64'(bus.fetch_count), 64'h4);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc",   64'(bus.imemaddr),    64'h0);
        check("async_rst_fcnt", 64'(bus.fetch_count), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Priority: jump over branch, jr over jump
        bus.jumpmux = 1'b1; bus.imm26 = 26'h10;
        tick(); check("jump_0x40", 64'(bus.imemaddr), 64'h40);
        bus.branchmux = 1'b1; bus.immext = 32'h100;
        tick(); check("jump_beats_branch", 64'(bus.imemaddr), 64'h40);
        bus.jrmux = 1'b1; bus.jr_target = 32'h200;
        tick(); check("jr_beats_all", 64'(bus.imemaddr), 64'h200);
        check("fcnt3", 64'(bus.fetch_count), 64'h3);
        clear_inputs();

        // Redirect during stall is held until en
        bus.branchmux = 1'b1; bus.immext = 32'h80;
        tick();
        check("stall_pend",    64'(bus.pend_valid), 64'h1);
        check("stall_pc_hold", 64'(bus.imemaddr),   64'h200);
        bus.branchmux = 1'b0;
        tick(); tick();
        check("idle_pend",    64'(bus.pend_valid),  64'h1);
        check("idle_pc_hold", 64'(bus.imemaddr),    64'h200);
        check("idle_fcnt",    64'(bus.fetch_count), 64'h3);
        bus.en = 1'b1;
        tick();
        check("pend_apply_pc",   64'(bus.imemaddr),   64'h80);
        check("pend_apply_flag", 64'(bus.pend_valid), 64'h0);

        // New redirect overrides pending one
        bus.en = 1'b0; bus.branchmux = 1'b1; bus.immext = 32'h80;
        tick();
        bus.en = 1'b1; bus.branchmux = 1'b0; bus.jumpmux = 1'b1; bus.imm26 = 26'h30;
        tick();
        check("override_pc",   64'(bus.imemaddr),   64'hC0);
        check("override_pend", 64'(bus.pend_valid), 64'h0);
        clear_inputs();

        // Newer stalled redirect overwrites older pending one
        bus.branchmux = 1'b1; bus.immext = 32'h80;
        tick();
        bus.immext = 32'h90;
        tick();
        bus.branchmux = 1'b0; bus.en = 1'b1;
        tick();
        check("overwrite_pc", 64'(bus.imemaddr),    64'h90);
        check("fcnt6",        64'(bus.fetch_count), 64'h6);

        // Halt without en does nothing
        bus.en = 1'b0; bus.halt = 1'b1;
        tick();
        check("halt_noen_flag", 64'(bus.halted),   64'h0);
        check("halt_noen_pc",   64'(bus.imemaddr), 64'h90);

        // Move to 0x24 then halt there, with a competing branch
        bus.halt = 1'b0; bus.en = 1'b1; bus.jumpmux = 1'b1; bus.imm26 = 26'h9;
        tick();
        check("jump_0x24", 64'(bus.imemaddr), 64'h24);
        bus.jumpmux = 1'b0;
        bus.halt = 1'b1; bus.branchmux = 1'b1; bus.immext = 32'h300;
        tick();
        check("halt_flag", 64'(bus.halted),      64'h1);
        check("halt_pc",   64'(bus.imemaddr),    64'h24);
        check("halt_pend", 64'(bus.pend_valid),  64'h0);
        check("halt_fcnt", 64'(bus.fetch_count), 64'h8);
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.branchmux = i[0];
            bus.jumpmux   = i[1];
            tick();
            check($sformatf("halted_pc_%0d", i), 64'(bus.imemaddr), 64'h24);
        end
        check("halted_fcnt_frozen", 64'(bus.fetch_count), 64'h8);
        check("halted_still",       64'(bus.halted),      64'h1);
        clear_inputs();

        // Wrap modulo 2^PC_W, then counter saturation
        do_reset();
        check("post_rst_halted", 64'(bus.halted), 64'h0);
        bus.en = 1'b1; bus.jrmux = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
        tick();
        check("jr_top", 64'(bus.imemaddr), 64'hFFFF_FFFC);
        bus.jrmux = 1'b0;
        tick();
        check("wrap_pc", 64'(bus.imemaddr), 64'h0);
        for (int i = 0; i < 20; i++) tick();
        check("fcnt_sat", 64'(bus.fetch_count), 64'hF);
        check("sat_pc",   64'(bus.imemaddr),    64'h50);
        clear_inputs();

        // Return-address stack (or its absence)
        do_reset();
        bus.en = 1'b1;
        tick(); tick(); tick(); tick();
        check("ras_pc10", 64'(bus.imemaddr), 64'h10);
        bus.call_push = 1'b1; bus.jumpmux = 1'b1; bus.imm26 = 26'hC;
        tick();
        check("call1_pc",  64'(bus.imemaddr), 64'h30);
        check("call1_top", 64'(bus.ras_top),  RAS ? 64'h14 : 64'h0);
        bus.imm26 = 26'h20;
        tick();
        check("call2_pc",  64'(bus.imemaddr), 64'h80);
        check("call2_top", 64'(bus.ras_top),  RAS ? 64'h34 : 64'h0);
        bus.call_push = 1'b0; bus.jumpmux = 1'b0;
        bus.jrmux = 1'b1; bus.ret_pop = 1'b1; bus.jr_target = 32'hFFF0;
        tick();
        check("ret1_pc",  64'(bus.imemaddr), RAS ? 64'h34 : 64'hFFF0);
        check("ret1_top", 64'(bus.ras_top),  RAS ? 64'h14 : 64'h0);
        tick();
        check("ret2_pc",  64'(bus.imemaddr), RAS ? 64'h14 : 64'hFFF0);
        check("ret2_top", 64'(bus.ras_top),  64'h0);
        tick();
        check("ret3_empty_pc", 64'(bus.imemaddr), 64'hFFF0);
        check("ret3_top",      64'(bus.ras_top),  64'h0);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
